conv_io_master: RTL and testbench

CONV_IO_MASTER -- requirements
Module: conv_io_master

---
 rtl/conv_io_master.sv | 195 +++++++++++++++++++
 tb/tb_conv_io_master.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_io_master.sv
// conv_io_master: moves upstream pixels into an accelerator input FIFO and
// drains its output FIFO to a downstream consumer through an io_clk strobe handshake.
// Latency: each FIFO transaction takes 1 + 2*IO_HALF cycles, with at least 1 IDLE cycle between transactions.
// Backpressure: s_ready pulses once per accepted pixel. A write is refused while FULL_in is high.
//   A read is refused while EMPTY_out is high or while m_valid is still held.
// Ports:
//   Clk, Rst                    - sole clock, asynchronous active-high reset
//   s_valid/s_data/s_eol/s_ready - upstream pixel stream (s_ready is a one-cycle accept pulse)
//   m_valid/m_data/m_ready       - downstream result word (held until consumed)
//   conv_en -> cStart            - accelerator run request, registered only while IDLE
//   bufferInput, wr, rd, io_clk, newline - accelerator FIFO strobes
//   bufferOutput, FULL_in, EMPTY_in, FULL_out, EMPTY_out - accelerator FIFO head and flags
//   busy                         - high for the whole transaction
//   timeout_err                  - sticky watchdog flag, present only when CONV_IO_TIMEOUT_EN is defined
// Optional feature macro: CONV_IO_TIMEOUT_EN (adds the write-stall watchdog and the timeout_err port).
`ifndef bitLength
`define bitLength 8
`endif

module conv_io_master #(
   parameter int IO_HALF = 2
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  s_valid,
   input  logic [`bitLength-1:0] s_data,
   input  logic                  s_eol,
   output logic                  s_ready,
   output logic                  m_valid,
   output logic [`bitLength-1:0] m_data,
   input  logic                  m_ready,
   input  logic                  conv_en,
   output logic [`bitLength-1:0] bufferInput,
   output logic                  wr,
   output logic                  rd,
   output logic                  io_clk,
   output logic                  newline,
   output logic                  cStart,
   input  logic [`bitLength-1:0] bufferOutput,
   input  logic                  FULL_in,
   input  logic                  EMPTY_in,
   input  logic                  FULL_out,
   input  logic                  EMPTY_out,
   output logic                  busy
`ifdef CONV_IO_TIMEOUT_EN
   ,
   output logic                  timeout_err
`endif
);

   localparam logic [3:0] HALF_M1 = 4'(IO_HALF - 1);

   typedef enum logic [2:0] {
      IDLE, WR_SETUP, WR_HI, WR_LO, RD_SETUP, RD_HI, RD_LO
   } state_t;

   state_t                  state, state_nxt;
   logic [3:0]              cnt, cnt_nxt;
   logic [`bitLength-1:0]   px_data;
   logic                    px_eol;
   logic                    pick_rd, pick_wr;

   // The FSM does not need these two flags. They are tied off here so they stay visible at the boundary.
   logic unused_flags;
   assign unused_flags = EMPTY_in | FULL_out;

   // IDLE arbitration. A read wins, so that the output FIFO drains before the master pushes more input.
   always_comb begin
      pick_rd = 1'b0;
      pick_wr = 1'b0;
      if (state == IDLE) begin
         if (!EMPTY_out && !m_valid)
            pick_rd = 1'b1;
         else if (s_valid && !FULL_in)
            pick_wr = 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            cnt_nxt = 4'd0;
            if (pick_rd)
               state_nxt = RD_SETUP;
            else if (pick_wr)
               state_nxt = WR_SETUP;
         end
         WR_SETUP: begin
            state_nxt = WR_HI;
            cnt_nxt   = HALF_M1;
         end
         WR_HI: begin
            if (cnt == 4'd0) begin
               state_nxt = WR_LO;
               cnt_nxt   = HALF_M1;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         WR_LO: begin
            if (cnt == 4'd0)
               state_nxt = IDLE;
            else
               cnt_nxt = cnt - 4'd1;
         end
         RD_SETUP: begin
            state_nxt = RD_HI;
            cnt_nxt   = HALF_M1;
         end
         RD_HI: begin
            if (cnt == 4'd0) begin
               state_nxt = RD_LO;
               cnt_nxt   = HALF_M1;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         RD_LO: begin
            if (cnt == 4'd0)
               state_nxt = IDLE;
            else
               cnt_nxt = cnt - 4'd1;
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
         end
      endcase
   end

   // The accept pulse is combinational from the IDLE decision.
   // It is gated by Rst so that it reads 0 while reset is held.
   assign s_ready = pick_wr && !Rst;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         px_data <= '0;
         px_eol  <= 1'b0;
         m_valid <= 1'b0;
         m_data  <= '0;
         cStart  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (pick_wr) begin
            px_data <= s_data;
            px_eol  <= s_eol;
         end
         if (state == IDLE)
            cStart <= conv_en;
         // The FIFO head is captured at the end of the io_clk high phase.
         // m_valid cannot already be set here, because a read only starts when it is clear.
         if (state == RD_HI && cnt == 4'd0) begin
            m_data  <= bufferOutput;
            m_valid <= 1'b1;
         end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
         end
      end
   end

   assign wr          = (state == WR_SETUP) || (state == WR_HI);
   assign rd          = (state == RD_SETUP) || (state == RD_HI);
   assign io_clk      = (state == WR_HI) || (state == RD_HI);
   assign newline     = wr && px_eol;
   assign bufferInput = px_data;
   assign busy        = (state != IDLE);

`ifdef CONV_IO_TIMEOUT_EN
   // This watchdog counts consecutive IDLE cycles in which a pixel waits on a full input FIFO.
   // The count saturates at all-ones. The flag it raises stays set until reset.
   logic [15:0] wd_cnt;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         wd_cnt      <= 16'd0;
         timeout_err <= 1'b0;
      end else begin
         if (state == IDLE && s_valid && FULL_in) begin
            if (wd_cnt != 16'hFFFF)
               wd_cnt <= wd_cnt + 16'd1;
         end else begin
            wd_cnt <= 16'd0;
         end
         if (wd_cnt == 16'hFFFF)
            timeout_err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_conv_io_master.sv
// tb_conv_io_master: self-checking bench for conv_io_master.
// Directed scenarios cover reset, single write, single read, arbitration, FIFO-full stall and mid-transaction reset.
// A randomized run is compared against a transaction-level reference model.
`timescale 1ns/1ps
`ifndef bitLength
`define bitLength 8
`endif

module tb_conv_io_master;

   localparam int H    = 2;
   localparam int W    = `bitLength;
   localparam int TLEN = 1 + 2*H;

   logic         Clk = 1'b0;
   logic         Rst;
   logic         s_valid, s_eol, s_ready, m_valid, m_ready, conv_en;
   logic [W-1:0] s_data, m_data, bufferInput, bufferOutput;
   logic         wr, rd, io_clk, newline, cStart, busy;
   logic         FULL_in, EMPTY_in, FULL_out, EMPTY_out;
`ifdef CONV_IO_TIMEOUT_EN
   logic         timeout_err;
`endif

   int n_vec = 0;
   int n_err = 0;

   conv_io_master #(.IO_HALF(H)) dut (
      .Clk(Clk), .Rst(Rst),
      .s_valid(s_valid), .s_data(s_data), .s_eol(s_eol), .s_ready(s_ready),
      .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
      .conv_en(conv_en), .bufferInput(bufferInput),
      .wr(wr), .rd(rd), .io_clk(io_clk), .newline(newline), .cStart(cStart),
      .bufferOutput(bufferOutput),
      .FULL_in(FULL_in), .EMPTY_in(EMPTY_in), .FULL_out(FULL_out), .EMPTY_out(EMPTY_out),
      .busy(busy)
`ifdef CONV_IO_TIMEOUT_EN
      , .timeout_err(timeout_err)
`endif
   );

   always #5 Clk = ~Clk;

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "time limit");
   end

   // Advance to 1 time unit after the next active edge. Inputs are driven from there.
   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   // Waits, with a bounded cycle budget, until the DUT reports idle.
   task automatic wait_idle();
      int t = 0;
      @(negedge Clk);
      while (busy !== 1'b0 && t < 50) begin
         @(negedge Clk);
         t++;
      end
      n_vec++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL wait_idle: busy got %b, required 0 within 50 cycles", busy);
      end
      step();
   endtask

   task automatic test_reset();
      Rst = 1'b1; conv_en = 1'b1; s_valid = 1'b1; s_data = '1; s_eol = 1'b1;
      m_ready = 1'b0; FULL_in = 1'b0; EMPTY_in = 1'b0; FULL_out = 1'b0; EMPTY_out = 1'b0;
      bufferOutput = '1;
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      n_vec++;
      if ({s_ready, wr, rd, io_clk, newline, cStart, m_valid, busy} !== 8'h00) begin
         n_err++;
         $display("FAIL reset_ctl: got %b, required 00000000",
                  {s_ready, wr, rd, io_clk, newline, cStart, m_valid, busy});
      end
      n_vec++;
      if ({m_data, bufferInput} !== '0) begin
         n_err++;
         $display("FAIL reset_data: m_data %h bufferInput %h, required 0", m_data, bufferInput);
      end
`ifdef CONV_IO_TIMEOUT_EN
      n_vec++;
      if (timeout_err !== 1'b0) begin
         n_err++;
         $display("FAIL reset_timeout: got %b, required 0", timeout_err);
      end
`endif
      step();
      Rst = 1'b0; conv_en = 1'b0; s_valid = 1'b0; EMPTY_out = 1'b1;
   endtask

   task automatic test_write(input logic [W-1:0] d, input logic e);
      logic [5:0] exp;
      s_valid = 1'b1; s_data = d; s_eol = e; FULL_in = 1'b0; EMPTY_out = 1'b1;
      @(negedge Clk);
      n_vec++;
      if (s_ready !== 1'b1) begin
         n_err++;
         $display("FAIL write_accept: s_ready got %b, required 1", s_ready);
      end
      step();
      s_valid = 1'b0; s_data = ~d; s_eol = ~e;
      for (int k = 0; k < TLEN; k++) begin
         @(negedge Clk);
         exp = {1'b0, (k <= H), 1'b0, (k >= 1 && k <= H), (e && k <= H), 1'b1};
         n_vec++;
         if ({s_ready, wr, rd, io_clk, newline, busy} !== exp) begin
            n_err++;
            $display("FAIL write_strobe k=%0d: {s_ready,wr,rd,io_clk,newline,busy} got %b, required %b",
                     k, {s_ready, wr, rd, io_clk, newline, busy}, exp);
         end
         if (k <= H) begin
            n_vec++;
            if (bufferInput !== d) begin
               n_err++;
               $display("FAIL write_data k=%0d: bufferInput got %h, required %h", k, bufferInput, d);
            end
         end
         step();
      end
      @(negedge Clk);
      n_vec++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL write_end: busy got %b, required 0", busy);
      end
      step();
   endtask

   task automatic test_read(input logic [W-1:0] v);
      logic [4:0] exp;
      EMPTY_out = 1'b0; bufferOutput = v; m_ready = 1'b0; s_valid = 1'b0;
      @(negedge Clk);
      n_vec++;
      if ({rd, busy, s_ready} !== 3'b000) begin
         n_err++;
         $display("FAIL read_decide: {rd,busy,s_ready} got %b, required 000", {rd, busy, s_ready});
      end
      step();
      for (int k = 0; k < TLEN; k++) begin
         @(negedge Clk);
         exp = {1'b0, (k <= H), (k >= 1 && k <= H), 1'b1, (k > H)};
         n_vec++;
         if ({wr, rd, io_clk, busy, m_valid} !== exp) begin
            n_err++;
            $display("FAIL read_strobe k=%0d: {wr,rd,io_clk,busy,m_valid} got %b, required %b",
                     k, {wr, rd, io_clk, busy, m_valid}, exp);
         end
         step();
      end
      // The result is held: no new read starts and m_data ignores a changing FIFO head.
      for (int j = 0; j < 8; j++) begin
         bufferOutput = W'($urandom);
         @(negedge Clk);
         n_vec++;
         if ({rd, busy, m_valid} !== 3'b001 || m_data !== v) begin
            n_err++;
            $display("FAIL read_hold j=%0d: {rd,busy,m_valid} %b m_data %h, required 001 and %h",
                     j, {rd, busy, m_valid}, m_data, v);
         end
         step();
      end
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      @(negedge Clk);
      n_vec++;
      if ({m_valid, busy, rd} !== 3'b000) begin
         n_err++;
         $display("FAIL read_consume: {m_valid,busy,rd} got %b, required 000", {m_valid, busy, rd});
      end
      step();
      EMPTY_out = 1'b1;
      @(negedge Clk);
      n_vec++;
      if (rd !== 1'b1) begin
         n_err++;
         $display("FAIL read_second: rd got %b, required 1 after consume", rd);
      end
      wait_idle();
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
   endtask

   task automatic test_priority(input logic [W-1:0] d);
      s_valid = 1'b1; s_data = d; s_eol = 1'b0; FULL_in = 1'b0; EMPTY_out = 1'b0;
      bufferOutput = W'($urandom);
      @(negedge Clk);
      n_vec++;
      if (s_ready !== 1'b0) begin
         n_err++;
         $display("FAIL prio_read_wins: s_ready got %b, required 0", s_ready);
      end
      step();
      EMPTY_out = 1'b1;
      @(negedge Clk);
      n_vec++;
      if ({rd, wr} !== 2'b10) begin
         n_err++;
         $display("FAIL prio_read_first: {rd,wr} got %b, required 10", {rd, wr});
      end
      repeat (TLEN) step();
      @(negedge Clk);
      n_vec++;
      if ({busy, s_ready, m_valid} !== 3'b011) begin
         n_err++;
         $display("FAIL prio_idle_gap: {busy,s_ready,m_valid} got %b, required 011", {busy, s_ready, m_valid});
      end
      step();
      s_valid = 1'b0;
      @(negedge Clk);
      n_vec++;
      if (wr !== 1'b1 || bufferInput !== d) begin
         n_err++;
         $display("FAIL prio_write_after: wr %b bufferInput %h, required 1 and %h", wr, bufferInput, d);
      end
      wait_idle();
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
   endtask

   task automatic test_full(input logic [W-1:0] d);
      FULL_in = 1'b1; s_valid = 1'b1; s_data = d; s_eol = 1'b1; EMPTY_out = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge Clk);
         n_vec++;
         if ({s_ready, wr, busy} !== 3'b000) begin
            n_err++;
            $display("FAIL full_stall i=%0d: {s_ready,wr,busy} got %b, required 000", i, {s_ready, wr, busy});
         end
         step();
      end
      FULL_in = 1'b0;
      @(negedge Clk);
      n_vec++;
      if (s_ready !== 1'b1) begin
         n_err++;
         $display("FAIL full_release: s_ready got %b, required 1", s_ready);
      end
      step();
      FULL_in = 1'b1;   // FIFO fills mid-write; the write must still complete
      s_valid = 1'b0;
      for (int k = 0; k < TLEN; k++) begin
         @(negedge Clk);
         n_vec++;
         if ({wr, busy} !== {(k <= H), 1'b1}) begin
            n_err++;
            $display("FAIL full_midwrite k=%0d: {wr,busy} got %b, required %b", k, {wr, busy}, {(k <= H), 1'b1});
         end
         step();
      end
      FULL_in = 1'b0;
   endtask

   task automatic test_reset_mid(input logic [W-1:0] d, input logic [W-1:0] v);
      EMPTY_out = 1'b0; bufferOutput = v; m_ready = 1'b0; s_valid = 1'b0; FULL_in = 1'b0;
      step();
      EMPTY_out = 1'b1;
      repeat (TLEN) step();
      s_valid = 1'b1; s_data = d; s_eol = 1'b1;
      @(negedge Clk);
      n_vec++;
      if ({s_ready, m_valid} !== 2'b11 || m_data !== v) begin
         n_err++;
         $display("FAIL rstmid_setup: {s_ready,m_valid} %b m_data %h, required 11 and %h", {s_ready, m_valid}, m_data, v);
      end
      step();
      s_valid = 1'b0;
      step();
      @(negedge Clk);
      n_vec++;
      if ({wr, io_clk, busy} !== 3'b111) begin
         n_err++;
         $display("FAIL rstmid_wrhi: {wr,io_clk,busy} got %b, required 111", {wr, io_clk, busy});
      end
      #2 Rst = 1'b1;
      #1;
      n_vec++;
      if ({wr, io_clk, busy, newline, m_valid} !== 5'b0 || {m_data, bufferInput} !== '0) begin
         n_err++;
         $display("FAIL rstmid_async: {wr,io_clk,busy,newline,m_valid} %b m_data %h bufferInput %h, required all 0",
                  {wr, io_clk, busy, newline, m_valid}, m_data, bufferInput);
      end
      step();
      Rst = 1'b0;
      for (int i = 0; i < 2*TLEN; i++) begin
         @(negedge Clk);
         n_vec++;
         if ({wr, rd, busy, m_valid} !== 4'b0000) begin
            n_err++;
            $display("FAIL rstmid_after i=%0d: {wr,rd,busy,m_valid} got %b, required 0000", i, {wr, rd, busy, m_valid});
         end
         step();
      end
   endtask

   // Transaction-level reference: a transaction is a run of TLEN cycles.
   // Each strobe is defined by its offset into that run.
   task automatic test_random(input int ncyc);
      int           rem, kk;
      bit           is_wr, mv, mv_n, cs, has_px, px_e, wr_e, rdy_exp, e_wr, e_rd, e_io;
      logic [W-1:0] px_d, wr_d, md;
      logic [7:0]   got, exp;
      Rst = 1'b1;
      step();
      Rst = 1'b0;
      rem = 0; mv = 1'b0; cs = 1'b0; has_px = 1'b0; is_wr = 1'b0;
      px_e = 1'b0; wr_e = 1'b0; px_d = '0; wr_d = '0; md = '0;
      for (int c = 0; c < ncyc; c++) begin
         if (!has_px && $urandom_range(2) == 0) begin
            has_px = 1'b1;
            px_d   = W'($urandom);
            px_e   = 1'($urandom);
         end
         s_valid      = has_px;
         s_data       = has_px ? px_d : W'($urandom);
         s_eol        = px_e;
         FULL_in      = ($urandom_range(3) == 0);
         EMPTY_out    = ($urandom_range(2) != 0);
         EMPTY_in     = 1'($urandom);
         FULL_out     = 1'($urandom);
         m_ready      = 1'($urandom);
         conv_en      = 1'($urandom);
         bufferOutput = W'($urandom);
         @(negedge Clk);
         kk      = TLEN - rem;
         rdy_exp = (rem == 0) && !(!EMPTY_out && !mv) && has_px && !FULL_in;
         e_wr    = (rem != 0) && is_wr && (kk <= H);
         e_rd    = (rem != 0) && !is_wr && (kk <= H);
         e_io    = (rem != 0) && (kk >= 1) && (kk <= H);
         exp = {rdy_exp, e_wr, e_rd, e_io, (e_wr && wr_e), (rem != 0), mv, cs};
         got = {s_ready, wr, rd, io_clk, newline, busy, m_valid, cStart};
         n_vec++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL rand_ctl cyc=%0d: {s_ready,wr,rd,io_clk,newline,busy,m_valid,cStart} got %b, required %b",
                     c, got, exp);
         end
         if (e_wr) begin
            n_vec++;
            if (bufferInput !== wr_d) begin
               n_err++;
               $display("FAIL rand_wdata cyc=%0d: bufferInput got %h, required %h", c, bufferInput, wr_d);
            end
         end
         if (mv) begin
            n_vec++;
            if (m_data !== md) begin
               n_err++;
               $display("FAIL rand_rdata cyc=%0d: m_data got %h, required %h", c, m_data, md);
            end
         end
         // Advance the model across the coming edge.
         mv_n = mv;
         if (rem != 0 && !is_wr && kk == H) begin
            mv_n = 1'b1;
            md   = bufferOutput;
         end else if (mv && m_ready) begin
            mv_n = 1'b0;
         end
         if (rem == 0) begin
            cs = conv_en;
            if (!EMPTY_out && !mv) begin
               rem = TLEN; is_wr = 1'b0;
            end else if (has_px && !FULL_in) begin
               rem = TLEN; is_wr = 1'b1; wr_d = px_d; wr_e = px_e; has_px = 1'b0;
            end
         end else begin
            rem--;
         end
         mv = mv_n;
         step();
      end
      s_valid = 1'b0; FULL_in = 1'b0; EMPTY_out = 1'b1; m_ready = 1'b0; conv_en = 1'b0;
   endtask

`ifdef CONV_IO_TIMEOUT_EN
   task automatic test_timeout();
      int t = 0;
      Rst = 1'b1;
      step();
      Rst = 1'b0; FULL_in = 1'b1; s_valid = 1'b1; s_data = '0; EMPTY_out = 1'b1;
      @(negedge Clk);
      while (timeout_err !== 1'b1 && t < 70000) begin
         @(negedge Clk);
         t++;
      end
      n_vec++;
      if (timeout_err !== 1'b1 || t < 65535 || t > 65537) begin
         n_err++;
         $display("FAIL timeout_set: timeout_err %b after %0d cycles, required 1 after 65535..65537", timeout_err, t);
      end
      step();
      FULL_in = 1'b0;
      step();
      s_valid = 1'b0;
      wait_idle();
      @(negedge Clk);
      n_vec++;
      if (timeout_err !== 1'b1) begin
         n_err++;
         $display("FAIL timeout_sticky: got %b, required 1", timeout_err);
      end
      step();
   endtask
`endif

   initial begin
      test_reset();
      test_write(W'(8'h5A), 1'b1);
      for (int i = 0; i < 3; i++) test_write(W'($urandom), 1'($urandom));
      test_read(W'(8'h3C));
      test_read(W'($urandom));
      test_priority(W'($urandom));
      test_full(W'($urandom));
      test_reset_mid(W'($urandom), W'($urandom));
      test_random(3000);
`ifdef CONV_IO_TIMEOUT_EN
      test_timeout();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
